mac_sequencer: RTL and testbench

Initiator for the single-cell MAC start/done handshake. It accepts a job of `len` operand pairs from an upstream valid/ready stream and presents each pair to one MAC cell. For each pair it drives the cell's start level, waits for the cell's done, and then releases start. After the last pair it captures the cell's accumulated 8-bit result and pulses `res_valid`. It sits between the operand buffers and one MAC cell, or the first cell of a systolic chain.

---
 rtl/mac_seq_pkg.sv | 16 +
 rtl/mac_seq_wdt.sv | 25 ++
 rtl/mac_sequencer.sv | 104 ++++++++++
 tb/tb_mac_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC start/done sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ARM,
    WAIT,
    RELEASE,
    REPORT
  } mac_seq_state_t;

  localparam int MAC_SEQ_LEN_W       = 5;
  localparam int MAC_SEQ_TIMEOUT_CYC = 64;

endpackage

// File: rtl/mac_seq_wdt.sv
// Watchdog for one MAC operation: cleared on load, counts while running,
// flags expiry on the LIMIT-th running cycle.
module mac_seq_wdt #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mac_sequencer.sv
// Drives one MAC cell through start/done handshakes for a job of len pairs.
// Optional watchdog: define MAC_SEQ_TIMEOUT_EN.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN_W       = MAC_SEQ_LEN_W,
  parameter int TIMEOUT_CYC = MAC_SEQ_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  input  logic [7:0]       op_b,
  input  logic [7:0]       op_c,
  output logic             op_ready,
  output logic [7:0]       mac_b,
  output logic [7:0]       mac_c,
  output logic             mac_st,
  input  logic             mac_done,
  input  logic [7:0]       mac_result,
  output logic             busy,
  output logic             res_valid,
  output logic [7:0]       res,
  output logic             err
);

  mac_seq_state_t   state, state_nx;
  logic [LEN_W-1:0] rem;
  logic             job_go, op_acc, done_hit, wdt_exp;

  assign job_go   = (state == IDLE) && start;
  assign op_acc   = (state == FETCH) && op_valid;
  assign done_hit = (state == WAIT) && mac_done && !wdt_exp;

`ifdef MAC_SEQ_TIMEOUT_EN
  mac_seq_wdt #(.LIMIT(TIMEOUT_CYC)) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (op_acc),
    .en      ((state == ARM) || (state == WAIT)),
    .expired (wdt_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)       err <= 1'b0;
    else if (job_go)  err <= 1'b0;
    else if (wdt_exp) err <= 1'b1;
  end
`else
  assign wdt_exp = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? REPORT : FETCH;
      FETCH:   if (op_valid) state_nx = ARM;
      // A done still high from the previous op is stale until it drops.
      ARM:     if (wdt_exp) state_nx = IDLE;
               else if (!mac_done) state_nx = WAIT;
      WAIT:    if (wdt_exp) state_nx = IDLE;
               else if (mac_done) state_nx = RELEASE;
      RELEASE: state_nx = (rem != '0) ? FETCH : REPORT;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      op_ready  <= 1'b0;
      mac_st    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      mac_b     <= '0;
      mac_c     <= '0;
      res       <= '0;
    end else begin
      state     <= state_nx;
      op_ready  <= (state_nx == FETCH);
      mac_st    <= (state_nx == ARM) || (state_nx == WAIT);
      busy      <= (state_nx != IDLE);
      res_valid <= (state_nx == REPORT);
      if (job_go) begin
        rem <= len;
        if (len == '0) res <= mac_result;
      end
      if (op_acc) begin
        mac_b <= op_b;
        mac_c <= op_c;
      end
      if (done_hit) begin
        rem <= rem - 1'b1;
        if (rem == LEN_W'(1)) res <= mac_result;
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with a behavioural MAC cell responder.
module tb_mac_sequencer;

  localparam int LEN_W = 5;
  localparam int TOC   = 64;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             start = 0;
  logic [LEN_W-1:0] len = '0;
  logic             op_valid = 0;
  logic [7:0]       op_b = '0, op_c = '0;
  logic             op_ready, mac_st, busy, res_valid, err;
  logic [7:0]       mac_b, mac_c, res;
  logic             mac_done = 0;
  logic [7:0]       mac_result = '0;

  mac_sequencer #(.LEN_W(LEN_W), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .op_valid(op_valid), .op_b(op_b), .op_c(op_c), .op_ready(op_ready),
    .mac_b(mac_b), .mac_c(mac_c), .mac_st(mac_st), .mac_done(mac_done),
    .mac_result(mac_result), .busy(busy), .res_valid(res_valid),
    .res(res), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int hs_cnt = 0, rv_cnt = 0;
  logic [15:0] exp_op[$];
  logic [7:0]  exp_res[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cell model: done rises lat cycles after start, clears on the next start.
  int  lat = 6;
  int  lat_cnt = 0;
  bit  never_done = 0;
  logic st_d = 0;
  always @(posedge clk) begin
    st_d <= mac_st;
    if (mac_st && !st_d) begin
      mac_done <= 1'b0;
      lat_cnt  <= lat;
    end else if (mac_st && lat_cnt > 0 && !never_done) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) mac_done <= 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an operand or result.
  logic       st_prev = 0;
  logic [7:0] held_b, held_c;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_st && !st_prev) begin
        hs_cnt++;
        held_b = mac_b;
        held_c = mac_c;
        if (exp_op.size() == 0) chk("op_unexpected", 1, 0);
        else chk("op_pair", {mac_b, mac_c}, exp_op.pop_front());
      end else if (mac_st) begin
        chk("op_stable", {mac_b, mac_c}, {held_b, held_c});
      end
      if (mac_st && op_ready) chk("ready_while_st", 1, 0);
      if (res_valid) begin
        rv_cnt++;
        if (exp_res.size() == 0) chk("res_unexpected", 1, 0);
        else chk("res", res, exp_res.pop_front());
      end
`ifndef MAC_SEQ_TIMEOUT_EN
      if (err) chk("err_tied", err, 0);
`endif
    end
    st_prev = mac_st;
  end

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1; len = LEN_W'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic feed(input logic [7:0] b, input logic [7:0] c);
    int t = 0;
    exp_op.push_back({b, c});
    op_valid = 1; op_b = b; op_c = c;
    while (!op_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("feed_timeout", 0, 1);
    @(negedge clk);
    op_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("idle_timeout", 0, 1);
  endtask

  logic [7:0] jb[8], jc[8];
  task automatic run_job(input int n, input logic [7:0] r);
    int h0 = hs_cnt, v0 = rv_cnt;
    mac_result = r;
    exp_res.push_back(r);
    do_start(n);
    for (int i = 0; i < n; i++) feed(jb[i], jc[i]);
    wait_idle();
    @(negedge clk);
    chk("job_handshakes", hs_cnt - h0, n);
    chk("job_res_valid", rv_cnt - v0, 1);
  endtask

  initial begin
    int h0, v0, hi, t;
    repeat (3) @(negedge clk);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_mac_st", mac_st, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);
    chk("rst_macbc", {mac_b, mac_c}, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    @(negedge clk);

    // basic three-op job
    jb[0] = 8'h38; jc[0] = 8'h40;
    jb[1] = 8'h30; jc[1] = 8'h38;
    jb[2] = 8'h40; jc[2] = 8'h40;
    run_job(3, 8'h52);
    chk("basic_res_hold", res, 8'h52);

    // stale done from previous op, short latency
    lat = 2;
    jb[0] = 8'h01; jc[0] = 8'h02;
    jb[1] = 8'hfe; jc[1] = 8'h7f;
    run_job(2, 8'hA5);
    lat = 6;

    // upstream backpressure between pairs
    mac_result = 8'h3c;
    exp_res.push_back(8'h3c);
    do_start(2);
    feed(8'h11, 8'h22);
    t = 0;
    while (!op_ready && t < 100) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      chk("bp_st_low", mac_st, 0);
      chk("bp_hold", {mac_b, mac_c}, 16'h1122);
      @(negedge clk);
    end
    feed(8'h33, 8'h44);
    wait_idle();

    // zero-length job
    h0 = hs_cnt; v0 = rv_cnt;
    mac_result = 8'h77;
    exp_res.push_back(8'h77);
    do_start(0);
    chk("zero_rv", res_valid, 1);
    chk("zero_res", res, 8'h77);
    wait_idle();
    @(negedge clk);
    chk("zero_hs", hs_cnt - h0, 0);
    chk("zero_rv_cnt", rv_cnt - v0, 1);

    // start while busy is ignored
    h0 = hs_cnt; v0 = rv_cnt;
    mac_result = 8'h19;
    exp_res.push_back(8'h19);
    do_start(1);
    feed(8'h5a, 8'ha5);
    start = 1; len = 5;
    @(negedge clk);
    start = 0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("busy_start_hs", hs_cnt - h0, 1);
    chk("busy_start_rv", rv_cnt - v0, 1);
    chk("busy_start_idle", busy, 0);

    // reset during WAIT of op 2 of 4
    mac_result = 8'hee;
    do_start(4);
    feed(8'h10, 8'h20);
    feed(8'h30, 8'h40);
    t = 0;
    while (!mac_st && t < 50) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    exp_op.delete();
    exp_res.delete();
    chk("mid_rst_op_ready", op_ready, 0);
    chk("mid_rst_mac_st", mac_st, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rv", res_valid, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_macbc", {mac_b, mac_c}, 0);
    chk("mid_rst_err", err, 0);
    rst_n = 1;
    @(negedge clk);
    jb[0] = 8'h0f; jc[0] = 8'hf0;
    run_job(1, 8'h64);

`ifdef MAC_SEQ_TIMEOUT_EN
    // watchdog: cell never completes
    never_done = 1;
    v0 = rv_cnt;
    do_start(1);
    feed(8'h21, 8'h43);
    hi = 1;  // feed returns one cycle into ARM
    t = 0;
    while (busy && t < 300) begin
      @(negedge clk);
      if (mac_st) hi++;
      t++;
    end
    chk("wdt_st_len", hi, TOC);
    chk("wdt_err", err, 1);
    chk("wdt_mac_st", mac_st, 0);
    chk("wdt_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("wdt_no_rv", rv_cnt - v0, 0);
    chk("wdt_err_sticky", err, 1);
    never_done = 0;
    jb[0] = 8'h02; jc[0] = 8'h03;
    run_job(1, 8'h06);
    chk("wdt_err_cleared", err, 0);
`endif

    chk("op_q_empty", exp_op.size(), 0);
    chk("res_q_empty", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
